// File: rtl/cla_wide_add_seq_if.sv
// Operand-request and result handshake bundle for the sequenced wide adder.
// The requester drives operands and out_ready; the adder drives everything else.
// Widths follow the slice width N and slice count WORDS of the attached adder.
interface cla_wide_add_seq_if #(
  parameter int N     = 4,
  parameter int WORDS = 4
);
  localparam int W = N * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum_out;
  logic         cout_out;
  logic         ovf_out;
  logic         busy;

  modport master (
    output in_valid, a_in, b_in, cin, sub, out_ready,
    input  in_ready, out_valid, sum_out, cout_out, ovf_out, busy
  );

  modport slave (
    input  in_valid, a_in, b_in, cin, sub, out_ready,
    output in_ready, out_valid, sum_out, cout_out, ovf_out, busy
  );
endinterface

// File: rtl/cla_wide_add_seq.sv
// Wide add/subtract built by stepping one N-bit carry-lookahead slice over WORDS slices, LSB slice first.
// Latency: result valid WORDS cycles after acceptance; minimum issue interval WORDS+2 cycles.
// Backpressure: accepts only in IDLE; holds the result in DONE until out_ready, new requests are dropped meanwhile.
module cla_wide_add_seq #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  cla_wide_add_seq_if.slave   bus
);
  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;        // already inverted for subtraction
  logic [W-1:0]  work_q;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  sum_q;
  logic          cout_q;
  logic          ovf_q;

  logic [N-1:0]  sa, sb, g, p, s;
  logic [N:0]    c;
  logic [W-1:0]  next_work;
  logic          last;
  logic          t;

  assign last = (idx == IW'(WORDS - 1));

  // Current slice operands; the base is a multiple of N so it never straddles slices.
  always_comb begin
    sa = a_q[int'(idx) * N +: N];
    sb = b_q[int'(idx) * N +: N];
  end

  // Flattened lookahead: every carry is an OR of generate terms masked by the
  // propagate run above them, with no ripple between bit positions.
  always_comb begin
    g    = sa & sb;
    p    = sa ^ sb;
    c    = '0;
    t    = 1'b0;
    c[0] = carry;
    for (int i = 0; i < N; i++) begin
      c[i+1] = g[i];
      t      = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (t & g[j]);
        t      = t & p[j];
      end
      c[i+1] = c[i+1] | (t & carry);
    end
    s = p ^ c[N-1:0];
  end

  // Working result with the current slice merged in, so the last slice can be
  // published in the same cycle it is computed.
  always_comb begin
    next_work = work_q;
    next_work[int'(idx) * N +: N] = s;
  end

  // Control FSM plus datapath registers; the result registers only move at completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.a_in;
            b_q   <= bus.sub ? ~bus.b_in : bus.b_in;
            carry <= bus.sub ? 1'b1 : bus.cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          work_q <= next_work;
          carry  <= c[N];
          if (last) begin
            sum_q  <= next_work;
            cout_q <= c[N];
            ovf_q  <= c[N] ^ c[N-1];
            idx    <= '0;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.sum_out   = sum_q;
  assign bus.cout_out  = cout_q;
  assign bus.ovf_out   = ovf_q;
endmodule

// File: tb/tb_cla_wide_add_seq.sv
// Directed bench for the sequenced wide adder at N=4, WORDS=4.
// Expected values are hand-computed constants per vector.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_cla_wide_add_seq;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;

  cla_wide_add_seq_if #(.N(4), .WORDS(4)) bus ();

  cla_wide_add_seq #(.N(4), .WORDS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One full operation; hold>0 keeps out_ready low for that many DONE cycles
  // while offering a competing request that must be ignored.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sb, input logic [15:0] es,
                        input logic ec, input logic eo, input int hold);
    int   lat;
    logic rdy_seen;
    logic stable;
    bus.a_in      = a;
    bus.b_in      = b;
    bus.cin       = ci;
    bus.sub       = sb;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    bus.a_in     = 16'hDEAD;
    bus.b_in     = 16'hBEEF;
    bus.cin      = ~ci;
    bus.sub      = ~sb;
    lat      = 0;
    rdy_seen = 1'b0;
    while (!bus.out_valid && lat < 20) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      step();
      lat++;
    end
    if (bus.in_ready) rdy_seen = 1'b1;
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk({tag, "_rdylow"}, 32'(rdy_seen), 32'd0);
    chk({tag, "_sum"}, 32'(bus.sum_out), 32'(es));
    chk({tag, "_cout"}, 32'(bus.cout_out), 32'(ec));
    chk({tag, "_ovf"}, 32'(bus.ovf_out), 32'(eo));
    if (hold > 0) begin
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        bus.in_valid = 1'b1;
        bus.a_in     = 16'h0F00 + 16'(i);
        bus.b_in     = 16'h0033;
        step();
        if (!bus.out_valid || !bus.busy || bus.in_ready || bus.sum_out !== es) stable = 1'b0;
      end
      chk({tag, "_hold"}, 32'(stable), 32'd1);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    step();
    chk({tag, "_idle_rdy"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_idle_vld"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_keep"}, 32'(bus.sum_out), 32'(es));
  endtask

  initial begin
    logic        seen;
    int          g;
    int          acc [3];
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic        vs [3];
    logic [15:0] ve [3];

    total = 0;
    bad   = 0;
    cyc   = 0;
    va = '{16'h1111, 16'hABCD, 16'h9000};
    vb = '{16'h2222, 16'h1234, 16'h1000};
    vs = '{1'b0, 1'b0, 1'b1};
    ve = '{16'h3333, 16'hBE01, 16'h8000};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    chk("rst_rdy", 32'(bus.in_ready), 32'd1);
    chk("rst_vld", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_sum", 32'(bus.sum_out), 32'd0);
    chk("rst_cout", 32'(bus.cout_out), 32'd0);
    chk("rst_ovf", 32'(bus.ovf_out), 32'd0);
    rst_n = 1'b1;
    step();

    run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
    run_op("add_carry", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    run_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    run_op("sub_neg_c0", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
    run_op("sub_neg_c1", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
    run_op("sub_ovf_c0", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);
    run_op("sub_ovf_c1", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);
    run_op("bp", 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 5);

    // Reset two edges after acceptance must abandon the operation silently.
    bus.a_in      = 16'h0F0F;
    bus.b_in      = 16'h0101;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_rdy", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_sum", 32'(bus.sum_out), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid) seen = 1'b1;
      step();
    end
    chk("mid_rst_novld", 32'(seen), 32'd0);
    run_op("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

    // Back-to-back with requests always offered and out_ready tied high.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.cin       = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.a_in = va[k];
      bus.b_in = vb[k];
      bus.sub  = vs[k];
      g = 0;
      while (!bus.in_ready && g < 20) begin
        step();
        g++;
      end
      acc[k] = cyc;
      step();
      g = 0;
      while (!bus.out_valid && g < 20) begin
        step();
        g++;
      end
      chk($sformatf("b2b_sum%0d", k), 32'(bus.sum_out), 32'(ve[k]));
      step();
    end
    bus.in_valid = 1'b0;
    chk("b2b_gap01", 32'(acc[1] - acc[0]), 32'd6);
    chk("b2b_gap12", 32'(acc[2] - acc[1]), 32'd6);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cla_wide_add_seq.md
# cla_wide_add_seq

Multi-cycle wide-operand adder/subtractor controller that sequences a single N-bit carry-lookahead slice over WORDS slices, least-significant slice first, to produce an (N·WORDS)-bit result. It sits between a requesting datapath and the shared CLA slice. Operands enter on a valid/ready handshake; the slice carry chains across cycles; the result leaves on a second valid/ready handshake.

## Interface
- N, 4, slice width in bits (≥1); slice uses G=A&B, P=A^B lookahead equations internally
- WORDS, 4, number of slices (≥1); total width W = N·WORDS
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand request
- in_ready  out  1  block can accept; high only in IDLE
- a_in  in  W  operand A
- b_in  in  W  operand B
- cin  in  1  carry-in (add mode only)
- sub  in  1  1 = compute A − B (A + ~B + 1, cin ignored)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- sum_out  out  W  result
- cout_out  out  1  carry out of MSB (sub: 1 = no borrow)
- ovf_out  out  1  signed overflow = carry into MSB XOR carry out of MSB
- busy  out  1  high in RUN and DONE

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready: latch A, B' = sub ? ~b_in : b_in, carry = sub ? 1 : cin; slice index = 0; go RUN.
- RUN: each cycle add slice[idx] of A and B' with carry through the CLA slice; write the N-bit slice sum into the working register at slice idx; carry ← slice carry-out; idx++. On idx = WORDS−1: also capture the MSB-bit carry-in for overflow; copy the completed working result, final carry and overflow into sum_out/cout_out/ovf_out; go DONE.
- DONE: out_valid=1. On out_ready go IDLE. Without out_ready, hold; all outputs stable.
- in_valid while in_ready=0 is ignored (not queued). Operand inputs are don't-care after acceptance.
- sum_out/cout_out/ovf_out change only at completion; they hold the last completed result through IDLE and RUN.
- Index counter width max(1, clog2(WORDS)). WORDS=1: RUN lasts one cycle.
- Arithmetic is modulo 2^W; carries beyond the MSB appear only on cout_out.

## Timing
- Reset (rst_n low at an edge): state IDLE, idx 0, carry 0. Registers cleared: sum_out=0, cout_out=0, ovf_out=0.
- Outputs after reset: out_valid=0, busy=0, in_ready=1 from the first cycle after the reset edge.
- Reset overrides every state. Reset mid-RUN or mid-DONE abandons the operation with no out_valid pulse.
- Acceptance edge E0. Slice k is processed at edge E0+k+1. out_valid rises after edge E0+WORDS (latency WORDS cycles).
- Result handshake completes at the first edge ≥ E0+WORDS+1 with out_ready=1. in_ready rises after that edge.
- Minimum issue interval: WORDS+2 cycles. out_ready held high gives exactly one DONE cycle.
- in_ready, out_valid and busy are decoded from registered state only. There is no combinational in→out path.

## Test plan (N=4, WORDS=4, W=16)
- Reset, then 0x1234 + 0x4321, cin=0, sub=0 → sum 0x5555, cout 0, ovf 0; out_valid rises exactly 4 cycles after acceptance; in_ready low during those 4 cycles.
- 0xFFFF + 0x0000, cin=1 → sum 0x0000, cout 1, ovf 0 (carry crosses all four slice boundaries); then 0x7FFF + 0x0001 → 0x8000, cout 0, ovf 1.
- sub=1: 0x0005 − 0x0007 → 0xFFFE, cout 0, ovf 0; 0x8000 − 0x0001 → 0x7FFF, cout 1, ovf 1; cin toggled in both cases with no effect.
- Backpressure: out_ready low for 5 cycles in DONE → out_valid, sum_out and busy held stable, in_ready 0, concurrent in_valid with new operands ignored; out_ready high → IDLE next cycle, previous result still on sum_out.
- Reset mid-RUN (rst_n low at edge E0+2): out_valid never asserts; next cycle in_ready=1, busy=0, sum_out=0. A fresh 0x0001 + 0x0001 then yields 0x0002.
- Back-to-back ops with out_ready tied high: accepts spaced exactly 6 cycles apart; results in order.
